// File: rtl/present_seq_pkg.sv
// present_seq_pkg
//   Shared constants and the sequencer state encoding for the PRESENT-80
//   core sequencer.
//   KEY_W   : PRESENT-80 key width
//   BLK_W   : PRESENT block width
//   state_e : sequencer FSM states
package present_seq_pkg;

  localparam int KEY_W = 80;
  localparam int BLK_W = 64;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_KEY = 3'd1,
    LOAD_PT  = 3'd2,
    WAIT     = 3'd3,
    OUT      = 3'd4
  } state_e;

endpackage

// File: rtl/present_core_sequencer.sv
// present_core_sequencer
//   Feeds a PRESENT-80 encryptor core: holds the key, reloads it before every
//   plaintext (the core consumes its key register while encrypting), loads the
//   plaintext, waits CORE_LATENCY cycles and presents the ciphertext on a
//   valid/ready output.
//
//   Handshakes: a transfer happens on a rising clk_i edge where both valid and
//   ready are 1. Ready never depends on the same channel's valid. Once
//   ct_valid_o is raised, ct_o stays stable until the ct handshake completes.
//
//   Ports
//     clk_i, rst_i          : clock, synchronous active-high reset
//     key_i/key_valid_i/key_ready_o : 80-bit key input channel
//     pt_i/pt_valid_i/pt_ready_o    : 64-bit plaintext input channel
//     ct_o/ct_valid_o/ct_ready_i    : 64-bit ciphertext output channel
//     core_data_o           : data bus to the encryptor core (key or {16'h0, pt})
//     core_key_load_o       : core key load strobe
//     core_data_load_o      : core plaintext load strobe
//     core_data_i           : encryptor core ciphertext
//     state_o               : debug view of the FSM state (present_seq_pkg::state_e)
//     blk_cnt_o             : completed-block counter, only with PRESENT_SEQ_BLK_CNT_EN
//
//   Build option: define PRESENT_SEQ_BLK_CNT_EN to add blk_cnt_o.
module present_core_sequencer
  import present_seq_pkg::*;
#(
  parameter int CORE_LATENCY = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [KEY_W-1:0]     key_i,
  input  logic                 key_valid_i,
  output logic                 key_ready_o,
  input  logic [BLK_W-1:0]     pt_i,
  input  logic                 pt_valid_i,
  output logic                 pt_ready_o,
  output logic [BLK_W-1:0]     ct_o,
  output logic                 ct_valid_o,
  input  logic                 ct_ready_i,
  output logic [KEY_W-1:0]     core_data_o,
  output logic                 core_key_load_o,
  output logic                 core_data_load_o,
  input  logic [BLK_W-1:0]     core_data_i,
`ifdef PRESENT_SEQ_BLK_CNT_EN
  output logic [15:0]          blk_cnt_o,
`endif
  output logic [2:0]           state_o
);

  // WAIT lasts CORE_LATENCY cycles: counter runs CORE_LATENCY-1 down to 0.
  localparam logic [7:0] LAT_M1 = 8'(CORE_LATENCY - 1);

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [BLK_W-1:0]  pt_q, pt_d;
  logic [BLK_W-1:0]  ct_q, ct_d;
  logic [KEY_W-1:0]  core_data_q, core_data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              key_ok_q, key_ok_d;
  // Low for the cycle following a reset edge so that every ready output is 0
  // then, even though the FSM already sits in IDLE.
  logic              ready_en_q;
  logic              ct_hs;

  always_comb begin
    state_d          = state_q;
    key_d            = key_q;
    pt_d             = pt_q;
    ct_d             = ct_q;
    core_data_d      = core_data_q;
    cnt_d            = cnt_q;
    key_ok_d         = key_ok_q;
    key_ready_o      = 1'b0;
    pt_ready_o       = 1'b0;
    ct_valid_o       = 1'b0;
    core_key_load_o  = 1'b0;
    core_data_load_o = 1'b0;
    ct_hs            = 1'b0;

    case (state_q)
      IDLE: begin
        key_ready_o = ready_en_q;
        // A pending key wins over a pending plaintext.
        pt_ready_o  = ready_en_q & key_ok_q & ~key_valid_i;
        if (key_valid_i && key_ready_o) begin
          key_d    = key_i;
          key_ok_d = 1'b1;
        end else if (pt_valid_i && pt_ready_o) begin
          pt_d    = pt_i;
          state_d = LOAD_KEY;
        end
      end
      LOAD_KEY: begin
        core_data_d     = key_q;
        core_key_load_o = 1'b1;
        state_d         = LOAD_PT;
      end
      LOAD_PT: begin
        core_data_d      = {16'h0000, pt_q};
        core_data_load_o = 1'b1;
        cnt_d            = LAT_M1;
        state_d          = WAIT;
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          ct_d    = core_data_i;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      OUT: begin
        ct_valid_o = 1'b1;
        if (ct_ready_i) begin
          ct_hs   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      key_q       <= '0;
      pt_q        <= '0;
      ct_q        <= '0;
      core_data_q <= '0;
      cnt_q       <= '0;
      key_ok_q    <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      pt_q        <= pt_d;
      ct_q        <= ct_d;
      core_data_q <= core_data_d;
      cnt_q       <= cnt_d;
      key_ok_q    <= key_ok_d;
      ready_en_q  <= 1'b1;
    end
  end

  // During the load states the bus shows the new value immediately; elsewhere
  // it holds whatever was last driven.
  assign core_data_o = core_data_d;
  assign ct_o        = ct_q;
  assign state_o     = state_q;

`ifdef PRESENT_SEQ_BLK_CNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_cnt_q <= '0;
    end else if (ct_hs) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt_o = blk_cnt_q;
`else
  logic unused_ct_hs;
  assign unused_ct_hs = ct_hs;
`endif

endmodule

// File: tb/tb_present_core_sequencer.sv
module tb_present_core_sequencer;

  localparam int CL = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [79:0] key_i = '0;
  logic        key_valid_i = 1'b0;
  logic        key_ready_o;
  logic [63:0] pt_i = '0;
  logic        pt_valid_i = 1'b0;
  logic        pt_ready_o;
  logic [63:0] ct_o;
  logic        ct_valid_o;
  logic        ct_ready_i = 1'b1;
  logic [79:0] core_data_o;
  logic        core_key_load_o;
  logic        core_data_load_o;
  logic [63:0] core_data_i;
  logic [2:0]  state_o;
`ifdef PRESENT_SEQ_BLK_CNT_EN
  logic [15:0] blk_cnt_o;
`endif

  present_core_sequencer #(.CORE_LATENCY(CL)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .key_i            (key_i),
    .key_valid_i      (key_valid_i),
    .key_ready_o      (key_ready_o),
    .pt_i             (pt_i),
    .pt_valid_i       (pt_valid_i),
    .pt_ready_o       (pt_ready_o),
    .ct_o             (ct_o),
    .ct_valid_o       (ct_valid_o),
    .ct_ready_i       (ct_ready_i),
    .core_data_o      (core_data_o),
    .core_key_load_o  (core_key_load_o),
    .core_data_load_o (core_data_load_o),
    .core_data_i      (core_data_i),
`ifdef PRESENT_SEQ_BLK_CNT_EN
    .blk_cnt_o        (blk_cnt_o),
`endif
    .state_o          (state_o)
  );

  // ---------------- encryptor core model ----------------
  // Known PRESENT-80 answers; ciphertext is only valid in the one cycle that
  // is CL cycles after the data load, and only if the key was freshly loaded
  // since the previous encryption (the real core consumes its key).
  localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

  function automatic logic [63:0] present_ref(input logic [79:0] k, input logic [63:0] p);
    if (k == 80'h0 && p == 64'h0)                   return 64'h5579C1387B228445;
    if (k == {80{1'b1}} && p == 64'h0)              return 64'hE72C46C0F5945049;
    if (k == {80{1'b1}} && p == 64'hFFFFFFFFFFFFFFFF) return 64'h3333DCD3213210D2;
    if (k == 80'h0 && p == 64'hFFFFFFFFFFFFFFFF)    return 64'hA112FFC72F68417B;
    return BAD;
  endfunction

  logic [79:0] m_key = '0;
  logic        m_fresh = 1'b0;
  logic [79:0] m_run_key = '0;
  logic [63:0] m_pt = '0;
  logic        m_run_fresh = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (core_key_load_o) begin
      m_key   <= core_data_o;
      m_fresh <= 1'b1;
    end
    if (core_data_load_o) begin
      m_pt        <= core_data_o[63:0];
      m_run_key   <= m_key;
      m_run_fresh <= m_fresh;
      m_fresh     <= 1'b0;
      m_cnt       <= CL;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign core_data_i = (m_cnt == 1 && m_run_fresh) ? present_ref(m_run_key, m_pt) : BAD;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_i = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("rst_state", 80'(state_o), 80'd0);
    check("rst_ready", {78'd0, key_ready_o, pt_ready_o}, 80'd0);
    check("rst_valid_loads", {77'd0, ct_valid_o, core_key_load_o, core_data_load_o}, 80'd0);
    check("rst_ct", 80'(ct_o), 80'd0);
    check("rst_core_data", core_data_o, 80'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic send_key(input logic [79:0] k);
    bit got = 0;
    key_i = k;
    key_valid_i = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (key_ready_o) got = 1;
      @(posedge clk); #1;
    end
    key_valid_i = 1'b0;
    key_i = {$urandom(), $urandom(), 16'($urandom())};
    if (!got) check("key_hs_timeout", 80'd0, 80'd1);
  endtask

  // Sends one plaintext, returns the handshake cycle and checks the two load
  // cycles plus the first WAIT cycle on the core bus.
  task automatic send_pt(input logic [63:0] p, input logic [79:0] k, output int t);
    bit got = 0;
    t = -1;
    pt_i = p;
    pt_valid_i = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (pt_ready_o) begin
        got = 1;
        t = cyc;
      end
      @(posedge clk); #1;
    end
    pt_valid_i = 1'b0;
    pt_i = {$urandom(), $urandom()};
    if (!got) begin
      check("pt_hs_timeout", 80'd0, 80'd1);
    end else begin
      @(negedge clk);
      check("load_key_strobes", {78'd0, core_key_load_o, core_data_load_o}, 80'd2);
      check("load_key_data", core_data_o, k);
      @(negedge clk);
      check("load_pt_strobes", {78'd0, core_key_load_o, core_data_load_o}, 80'd1);
      check("load_pt_data", core_data_o, {16'h0000, p});
      @(negedge clk);
      check("wait_strobes", {78'd0, core_key_load_o, core_data_load_o}, 80'd0);
      check("wait_data_hold", core_data_o, {16'h0000, p});
    end
  endtask

  task automatic wait_ct(output int t);
    t = -1;
    for (int i = 0; i < CL + 20 && t < 0; i++) begin
      if (ct_valid_o) t = cyc;
      else @(negedge clk);
    end
    if (t < 0) check("ct_valid_timeout", 80'd0, 80'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [79:0] key;
    logic [63:0] pt;
    logic        new_key;
    logic [63:0] exp_ct;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int t_pt, t_ct, t_key;
    int seen_valid, seen_ready;

    vecs[0] = '{key: 80'h0,        pt: 64'h0,                new_key: 1'b1, exp_ct: 64'h5579C1387B228445};
    vecs[1] = '{key: {80{1'b1}},   pt: 64'h0,                new_key: 1'b1, exp_ct: 64'hE72C46C0F5945049};
    vecs[2] = '{key: {80{1'b1}},   pt: 64'hFFFFFFFFFFFFFFFF, new_key: 1'b0, exp_ct: 64'h3333DCD3213210D2};
    vecs[3] = '{key: 80'h0,        pt: 64'hFFFFFFFFFFFFFFFF, new_key: 1'b1, exp_ct: 64'hA112FFC72F68417B};

    do_reset(3);

    // Tests 1 and 2: table, ct_ready_i held high.
    ct_ready_i = 1'b1;
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].new_key) send_key(vecs[v].key);
      send_pt(vecs[v].pt, vecs[v].key, t_pt);
      wait_ct(t_ct);
      check($sformatf("v%0d_latency", v), 80'(t_ct), 80'(t_pt + 3 + CL));
      check($sformatf("v%0d_ct", v), 80'(ct_o), 80'(vecs[v].exp_ct));
      @(negedge clk);
      check($sformatf("v%0d_one_cycle_out", v), {78'd0, ct_valid_o, key_ready_o}, 80'd1);
    end

    // Test 3: stall the output for 10 cycles with a plaintext waiting.
    send_pt(64'hFFFFFFFFFFFFFFFF, 80'h0, t_pt);
    ct_ready_i = 1'b0;
    wait_ct(t_ct);
    pt_i = 64'h0;
    pt_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("stall_ct", 80'(ct_o), 80'(64'hA112FFC72F68417B));
      check("stall_flags", {78'd0, ct_valid_o, pt_ready_o}, 80'd2);
      @(negedge clk);
    end
    pt_valid_i = 1'b0;
    ct_ready_i = 1'b1;
    @(negedge clk);
    check("stall_release_idle", 80'(state_o), 80'd0);

    // Test 4: pt before any key, then key and pt together.
    do_reset(2);
    pt_i = 64'h0;
    pt_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pt_without_key", {79'd0, pt_ready_o}, 80'd0);
    end
    @(posedge clk); #1;
    key_i = 80'h0;
    key_valid_i = 1'b1;
    @(negedge clk);
    check("both_valid_ready", {78'd0, key_ready_o, pt_ready_o}, 80'd2);
    t_key = cyc;
    @(posedge clk); #1;
    key_valid_i = 1'b0;
    @(negedge clk);
    check("pt_after_key", {79'd0, pt_ready_o}, 80'd1);
    check("pt_next_cycle", 80'(cyc), 80'(t_key + 1));
    t_pt = cyc;
    @(posedge clk); #1;
    pt_valid_i = 1'b0;
    wait_ct(t_ct);
    check("t4_latency", 80'(t_ct), 80'(t_pt + 3 + CL));
    check("t4_ct", 80'(ct_o), 80'(64'h5579C1387B228445));
    @(negedge clk);

    // Test 5: reset in the middle of WAIT.
    send_pt(64'h0, 80'h0, t_pt);
    repeat (10) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    pt_valid_i = 1'b1;
    seen_valid = 0;
    seen_ready = 0;
    for (int i = 0; i < 2 * CL; i++) begin
      @(negedge clk);
      if (ct_valid_o) seen_valid++;
      if (pt_ready_o) seen_ready++;
    end
    pt_valid_i = 1'b0;
    check("abort_no_ct_valid", 80'(seen_valid), 80'd0);
    check("abort_no_pt_ready", 80'(seen_ready), 80'd0);
    check("abort_idle", 80'(state_o), 80'd0);
    send_key({80{1'b1}});
    send_pt(64'hFFFFFFFFFFFFFFFF, {80{1'b1}}, t_pt);
    wait_ct(t_ct);
    check("t5_ct", 80'(ct_o), 80'(64'h3333DCD3213210D2));
    @(negedge clk);

`ifdef PRESENT_SEQ_BLK_CNT_EN
    // Test 6: block counter wrap.
    @(posedge clk); #1;
    force dut.blk_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.blk_cnt_q;
    check("blk_cnt_preload", 80'(blk_cnt_o), 80'(16'hFFFE));
    send_pt(64'h0, {80{1'b1}}, t_pt);
    wait_ct(t_ct);
    @(negedge clk);
    check("blk_cnt_ffff", 80'(blk_cnt_o), 80'(16'hFFFF));
    send_pt(64'h0, {80{1'b1}}, t_pt);
    wait_ct(t_ct);
    @(negedge clk);
    check("blk_cnt_wrap", 80'(blk_cnt_o), 80'(16'h0000));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/present_core_sequencer.md
PRESENT_CORE_SEQUENCER -- requirements
Module: present_core_sequencer

Interface
REQ-001 The block SHALL have parameter CORE_LATENCY, default 32, meaning cycles from the core data-load cycle to the cycle valid ciphertext is sampled on core_data_i; legal range 2..255.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: clk_i input 1, rising-edge clock; rst_i input 1, synchronous active-high reset.
REQ-003 key_i input 80, encryption key; key_valid_i input 1; key_ready_o output 1.
REQ-004 pt_i input 64, plaintext block; pt_valid_i input 1; pt_ready_o output 1.
REQ-005 ct_o output 64, ciphertext; ct_valid_o output 1; ct_ready_i input 1.
REQ-006 core_data_o output 80, drives the encryptor core data input; core_key_load_o output 1; core_data_load_o output 1.
REQ-007 core_data_i input 64, the encryptor core ciphertext output.

Function
REQ-008 The FSM SHALL have the states IDLE, LOAD_KEY, LOAD_PT, WAIT and OUT.
REQ-009 key_ready_o SHALL be 1 only in IDLE; a key handshake (key_valid_i and key_ready_o) SHALL store key_i in key_reg and set key_ok.
REQ-010 pt_ready_o SHALL be 1 only in IDLE with key_ok=1 and key_valid_i=0 (key has priority when both are valid); a pt handshake SHALL store pt_i in pt_reg and move to LOAD_KEY.
REQ-011 LOAD_KEY SHALL last 1 cycle with core_data_o=key_reg and core_key_load_o=1, then go to LOAD_PT.
REQ-012 The stored key SHALL be reloaded into the core before every plaintext, because the core consumes its key register during encryption.
REQ-013 LOAD_PT SHALL last 1 cycle with core_data_o={16'h0000, pt_reg} and core_data_load_o=1, then go to WAIT.
REQ-014 Outside LOAD_KEY and LOAD_PT, core_key_load_o and core_data_load_o SHALL both be 0; they SHALL never be 1 in the same cycle.
REQ-015 Outside LOAD_KEY and LOAD_PT, core_data_o SHALL hold its last driven value.
REQ-016 WAIT SHALL last exactly CORE_LATENCY cycles, using an 8-bit down-counter loaded with CORE_LATENCY-1 on entry.
REQ-017 On the WAIT cycle with counter=0, core_data_i SHALL be registered into ct_o and the FSM SHALL go to OUT.
REQ-018 Latency: for a pt handshake in cycle T, ct_valid_o SHALL first be 1 in cycle T+3+CORE_LATENCY.
REQ-019 In OUT, ct_valid_o SHALL be 1 and ct_o SHALL be stable until ct_ready_i=1; on that handshake the FSM SHALL return to IDLE.
REQ-020 ct_ready_i held high SHALL give a one-cycle OUT; the next pt may be accepted in the following IDLE cycle.
REQ-021 key_i and pt_i SHALL be ignored outside their handshakes, and key_reg SHALL NOT change while a block is in flight.

Reset
REQ-022 While rst_i=1 at a clock edge the block SHALL enter IDLE, clear key_ok, key_reg, pt_reg, ct_o, core_data_o and the counter to 0, and drive all valid, ready and load outputs to 0 in the following cycle.
REQ-023 Reset in any state (including WAIT or OUT) SHALL abort the block in flight, produce no ct_valid_o for it, and require a new key before any pt is accepted.

Configuration
REQ-024 With macro PRESENT_SEQ_BLK_CNT_EN defined, the block SHALL have output blk_cnt_o (16 bits), reset to 0, incrementing on each ct handshake and wrapping 16'hFFFF to 16'h0000.
REQ-025 Without PRESENT_SEQ_BLK_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 A shared package present_seq_pkg SHALL hold the constants KEY_W=80 and BLK_W=64 and the state enum typedef (IDLE, LOAD_KEY, LOAD_PT, WAIT, OUT).
REQ-027 The block SHALL have no sub-module: FSM, counter and registers are in one module, instantiated upstream of present_encryptor_top.

Verification
REQ-028 Test 1: reset, then key 80'h0 followed by pt 64'h0 -> ct_o=64'h5579C1387B228445 with ct_valid_o rising exactly CORE_LATENCY+3 cycles after the pt handshake.
REQ-029 Test 2: key all-ones, pt 64'h0 -> 64'hE72C46C0F5945049; then pt all-ones with no new key -> 64'h3333DCD3213210D2 (key reload proven).
REQ-030 Test 3: key 80'h0, pt all-ones -> 64'hA112FFC72F68417B; hold ct_ready_i=0 for 10 cycles -> ct_o and ct_valid_o stable and pt_ready_o=0 throughout.
REQ-031 Test 4: pt_valid_i=1 before any key -> pt_ready_o=0; key_valid_i and pt_valid_i in the same IDLE cycle -> key accepted first, pt accepted the next cycle.
REQ-032 Test 5: assert rst_i mid-WAIT -> no ct_valid_o, key_ok cleared, pt_ready_o=0 until a new key is accepted.
REQ-033 Test 6 (PRESENT_SEQ_BLK_CNT_EN defined): preload blk_cnt_o to 16'hFFFE by force, complete 2 blocks -> blk_cnt_o reads 16'hFFFF, then 16'h0000.
